// File: rtl/blackjack_auto_player.sv
// Threshold-strategy auto player for the blackJack core: plays one hand per start and keeps saturating tallies.
// Optional build macro PLAYER_DEALER_AWARE_EN also stands on 12..STAND_AT-1 against a dealer showing 2..6.
module blackjack_auto_player #(
  parameter int unsigned STAND_AT       = 17,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned MAX_HITS       = 11,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TALLY_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         player_score,
  input  logic [7:0]         dealer_score,
  input  logic               win,
  input  logic               lose,
  input  logic               tie,
  output logic               hit,
  output logic               stay,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [TALLY_W-1:0] games_won,
  output logic [TALLY_W-1:0] games_lost,
  output logic [TALLY_W-1:0] games_tied
);

  localparam int unsigned SW = (SETTLE_CYCLES  < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned HW = (MAX_HITS       < 1) ? 1 : $clog2(MAX_HITS + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);
  localparam logic [HW-1:0] HIT_LIMIT   = HW'(MAX_HITS);
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    STAND_B     = 8'(STAND_AT);

  localparam logic [1:0] RES_TIMEOUT = 2'b00;
  localparam logic [1:0] RES_WIN     = 2'b01;
  localparam logic [1:0] RES_LOSE    = 2'b10;
  localparam logic [1:0] RES_TIE     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DECIDE,
    HIT_S,
    STAND,
    RECORD
  } state_t;

  state_t state, state_d;

  logic [SW-1:0]      settle_cnt, settle_cnt_d;
  logic [HW-1:0]      hit_cnt, hit_cnt_d;
  logic [TW-1:0]      tmo_cnt, tmo_cnt_d;
  logic [1:0]         outcome, outcome_d;
  logic               hit_d, stay_d, busy_d, done_d;
  logic [1:0]         result_d;
  logic [TALLY_W-1:0] won_d, lost_d, tied_d;
  logic               stand_now;

`ifdef PLAYER_DEALER_AWARE_EN
  logic dealer_weak;
  always_comb begin
    dealer_weak = (player_score >= 8'd12) && (player_score < STAND_B) &&
                  (dealer_score >= 8'd2)  && (dealer_score <= 8'd6);
  end
`else
  logic unused_dealer;
  always_comb unused_dealer = ^dealer_score;
`endif

  always_comb begin
    stand_now = (player_score >= STAND_B) || (player_score > 8'd21) || (hit_cnt == HIT_LIMIT);
`ifdef PLAYER_DEALER_AWARE_EN
    stand_now = stand_now || dealer_weak;
`endif
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    hit_cnt_d    = hit_cnt;
    tmo_cnt_d    = tmo_cnt;
    outcome_d    = outcome;
    result_d     = result;
    won_d        = games_won;
    lost_d       = games_lost;
    tied_d       = games_tied;

    case (state)
      IDLE: begin
        if (start) begin
          settle_cnt_d = SETTLE_INIT;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt - SW'(1);
        if (settle_cnt <= SW'(1)) state_d = DECIDE;
      end
      DECIDE: begin
        state_d = stand_now ? STAND : HIT_S;
      end
      HIT_S: begin
        hit_cnt_d    = hit_cnt + HW'(1);
        settle_cnt_d = SETTLE_INIT;
        state_d      = SETTLE;
      end
      STAND: begin
        if (lose) begin
          outcome_d = RES_LOSE;
          state_d   = RECORD;
        end else if (win) begin
          outcome_d = RES_WIN;
          state_d   = RECORD;
        end else if (tie) begin
          outcome_d = RES_TIE;
          state_d   = RECORD;
        end else if (tmo_cnt == TMO_LIMIT) begin
          outcome_d = RES_TIMEOUT;
          state_d   = RECORD;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      RECORD: begin
        result_d  = outcome;
        hit_cnt_d = '0;
        tmo_cnt_d = '0;
        state_d   = IDLE;
        case (outcome)
          RES_WIN:  if (games_won  != '1) won_d  = games_won  + TALLY_W'(1);
          RES_LOSE: if (games_lost != '1) lost_d = games_lost + TALLY_W'(1);
          RES_TIE:  if (games_tied != '1) tied_d = games_tied + TALLY_W'(1);
          default:  ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // hit/stay/done follow the state one cycle later; busy also rises on the accepting edge
    hit_d  = (state == HIT_S);
    stay_d = (state == STAND);
    done_d = (state == RECORD);
    busy_d = (state != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      hit_cnt    <= '0;
      tmo_cnt    <= '0;
      outcome    <= '0;
      hit        <= 1'b0;
      stay       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      games_won  <= '0;
      games_lost <= '0;
      games_tied <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      hit_cnt    <= hit_cnt_d;
      tmo_cnt    <= tmo_cnt_d;
      outcome    <= outcome_d;
      hit        <= hit_d;
      stay       <= stay_d;
      busy       <= busy_d;
      done       <= done_d;
      result     <= result_d;
      games_won  <= won_d;
      games_lost <= lost_d;
      games_tied <= tied_d;
    end
  end

endmodule
